fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register of the MIPS datapath.
- Drives the program counter and handshakes with instruction memory.
- Registers each fetched instruction into IF/ID, with stall, flush and branch-redirect control.
- Its Imm16_ID output feeds the decode-stage sign-extension unit.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
Clk  input  1  rising-edge clock.
Reset_n  input  1  asynchronous, active-low reset.
Stall  input  1  hazard-unit stall; hold IF/ID and PC.
Flush  input  1  insert bubble into IF/ID on next edge.
BranchTaken  input  1  redirect fetch to BranchTarget (from EX).
BranchTarget  input  32  redirect address; bits [1:0] ignored (treated as 00).
IMemReq  output  1  fetch request to instruction memory.
IMemAddr  output  32  fetch address; equals PC.
IMemReady  input  1  memory returns IMemData this cycle.
IMemData  input  32  instruction word.
Instr_ID  output  32  IF/ID instruction.
PCPlus4_ID  output  32  IF/ID PC+4 of that instruction.
Valid_ID  output  1  IF/ID holds a real instruction.
Imm16_ID  output  16  Instr_ID[15:0], driven combinationally to the sign extender.

Behaviour:
- Reset (async, Reset_n=0):
  - PC=RESET_PC; state=START; RedirTarget=0; buffer empty.
  - Instr_ID=0 (nop), PCPlus4_ID=0, Valid_ID=0.
  - IMemReq=0.
- States: START, FETCH, HOLD, DRAIN.
- Control outputs: IMemReq=1 only in FETCH and DRAIN. IMemAddr=PC at all times, with PC[1:0] always 00.
- START:
  - Next edge goes to FETCH.
  - The first request appears the cycle after reset release.
- FETCH, IMemReady=0:
  - Hold PC and the request.
  - IF/ID holds unless Flush.
- FETCH, IMemReady=1, Stall=0:
  - Instr_ID<=IMemData, PCPlus4_ID<=PC+4, Valid_ID<=1.
  - PC<=PC+4.
  - Stay FETCH.
  - Throughput is one instruction per cycle when memory is zero-wait.
- FETCH, IMemReady=1, Stall=1:
  - Capture IMemData and PC+4 into a one-entry skid buffer.
  - PC<=PC+4; go HOLD.
  - IF/ID unchanged.
- HOLD:
  - No request.
  - When Stall=0: IF/ID<=buffer, Valid_ID<=1, go FETCH.
  - While Stall=1: remain in HOLD.
- Branch redirect (BranchTaken=1) has top priority over Stall and normal fetch; IF/ID always becomes a bubble on that edge.
  - FETCH with IMemReady=1: discard data, PC<=BranchTarget, stay FETCH.
  - FETCH with IMemReady=0: RedirTarget<=BranchTarget, go DRAIN.
    - Keep IMemAddr stable, since memory requires the address held until Ready.
  - HOLD: discard buffer, PC<=BranchTarget, go FETCH.
  - DRAIN: RedirTarget<=BranchTarget (newest wins).
- DRAIN:
  - On IMemReady=1: discard IMemData, PC<=RedirTarget (or BranchTarget if BranchTaken is asserted that cycle), go FETCH.
  - IF/ID stays a bubble unless Stall holds it.
- Bubble: Instr_ID<=32'h0000_0000, PCPlus4_ID<=0, Valid_ID<=0.
- Flush without BranchTaken:
  - Bubble IF/ID on the edge; Flush beats Stall.
  - PC, state and skid buffer are unaffected.
  - In HOLD, the buffered instruction is kept; it is the next instruction, not the flushed one.
- Arithmetic:
  - PC+4 is computed modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
  - No other arithmetic in the block.
- Reset mid-operation:
  - Asserting Reset_n=0 in any state immediately forces all reset values.
  - Any in-flight memory transaction is abandoned.
- Invariant: Valid_ID=0 whenever Instr_ID is the bubble value.

Test Plan:
- Reset release, RESET_PC=0, IMemReady tied 1, memory returns addr-encoded words → IMemAddr sequence 0,4,8,C on consecutive cycles; Instr_ID follows one cycle later; PCPlus4_ID=4,8,C; Valid_ID=1 from the second active edge.
- Stall high 3 cycles while IMemReady=1 at PC=8 → state HOLD, IMemReq=0, Instr_ID held at word@4; after Stall drops, Instr_ID=word@8, next IMemAddr=C, no instruction lost or duplicated.
- IMemReady low 2 cycles at PC=10, BranchTaken with BranchTarget=32'h100 in the first wait cycle → IMemAddr stays 10 until Ready, returned word discarded, Valid_ID=0; next IMemAddr=100.
- BranchTaken with Stall=1 in HOLD → buffer dropped, PC=target, Instr_ID=0, Valid_ID=0 on that edge.
- Flush alone with IMemReady=1 → bubble in IF/ID; PC still advances by 4; Imm16_ID=16'h0000.
- RESET_PC=32'hFFFF_FFF8, zero-wait memory → IMemAddr FFFF_FFF8, FFFF_FFFC, 0000_0000; reset pulse mid-DRAIN → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC, instruction-memory handshake and IF/ID register.
// A one-entry skid buffer catches a word that returns while decode is stalled.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemReady,
  input  logic [31:0] IMemData,
  output logic [31:0] Instr_ID,
  output logic [31:0] PCPlus4_ID,
  output logic        Valid_ID,
  output logic [15:0] Imm16_ID
);

  localparam logic [1:0] START = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  localparam logic [31:0] PC_INIT = RESET_PC & ~32'h3;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] redir_q, redir_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc4_q, buf_pc4_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic        bubble;
  logic [31:0] pc_plus4;
  logic [31:0] tgt;

  assign pc_plus4 = pc_q + 32'd4;
  assign tgt      = BranchTarget & ~32'h3;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    redir_d     = redir_q;
    buf_instr_d = buf_instr_q;
    buf_pc4_d   = buf_pc4_q;
    instr_d     = instr_q;
    pc4_d       = pc4_q;
    valid_d     = valid_q;
    bubble      = Flush | BranchTaken;
    case (state_q)
      START: begin
        state_d = FETCH;
        if (BranchTaken) pc_d = tgt;
      end
      FETCH: begin
        if (BranchTaken) begin
          // Memory needs the address held until Ready, so park the target.
          if (IMemReady) pc_d = tgt;
          else begin
            redir_d = tgt;
            state_d = DRAIN;
          end
        end else if (IMemReady) begin
          pc_d = pc_plus4;
          if (!Stall) begin
            instr_d = IMemData;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
          end else begin
            buf_instr_d = IMemData;
            buf_pc4_d   = pc_plus4;
            state_d     = HOLD;
          end
        end
      end
      HOLD: begin
        if (BranchTaken) begin
          pc_d    = tgt;
          state_d = FETCH;
        end else if (!Stall && !Flush) begin
          // A flush here bubbles IF/ID but keeps the buffered (younger) word.
          instr_d = buf_instr_q;
          pc4_d   = buf_pc4_q;
          valid_d = 1'b1;
          state_d = FETCH;
        end
      end
      default: begin
        if (BranchTaken) redir_d = tgt;
        if (IMemReady) begin
          pc_d    = BranchTaken ? tgt : redir_q;
          state_d = FETCH;
        end
        if (!Stall) bubble = 1'b1;
      end
    endcase
    if (bubble) begin
      instr_d = 32'h0000_0000;
      pc4_d   = 32'h0000_0000;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= START;
      pc_q        <= PC_INIT;
      redir_q     <= 32'h0000_0000;
      buf_instr_q <= 32'h0000_0000;
      buf_pc4_q   <= 32'h0000_0000;
      instr_q     <= 32'h0000_0000;
      pc4_q       <= 32'h0000_0000;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      redir_q     <= redir_d;
      buf_instr_q <= buf_instr_d;
      buf_pc4_q   <= buf_pc4_d;
      instr_q     <= instr_d;
      pc4_q       <= pc4_d;
      valid_q     <= valid_d;
    end
  end

  assign IMemReq    = (state_q == FETCH) || (state_q == DRAIN);
  assign IMemAddr   = pc_q;
  assign Instr_ID   = instr_q;
  assign PCPlus4_ID = pc4_q;
  assign Valid_ID   = valid_q;
  assign Imm16_ID   = instr_q[15:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; memory returns {A5A5, addr[15:0]} for every fetch.
module tb_fetch_stage;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        Stall, Flush, BranchTaken, IMemReady;
  logic [31:0] BranchTarget;

  logic        IMemReq, Valid_ID;
  logic [31:0] IMemAddr, IMemData, Instr_ID, PCPlus4_ID;
  logic [15:0] Imm16_ID;

  logic        IMemReq2, Valid_ID2;
  logic [31:0] IMemAddr2, IMemData2, Instr_ID2, PCPlus4_ID2;
  logic [15:0] Imm16_ID2;

  int nvec = 0;
  int nerr = 0;

  always #5 Clk = ~Clk;

  assign IMemData  = {16'hA5A5, IMemAddr[15:0]};
  assign IMemData2 = {16'hA5A5, IMemAddr2[15:0]};

  fetch_stage #(.RESET_PC(32'h0000_0000)) u_dut (
    .Clk(Clk), .Reset_n(Reset_n), .Stall(Stall), .Flush(Flush),
    .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemReady(IMemReady), .IMemData(IMemData),
    .Instr_ID(Instr_ID), .PCPlus4_ID(PCPlus4_ID), .Valid_ID(Valid_ID), .Imm16_ID(Imm16_ID)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
    .Clk(Clk), .Reset_n(Reset_n), .Stall(Stall), .Flush(Flush),
    .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .IMemReq(IMemReq2), .IMemAddr(IMemAddr2), .IMemReady(IMemReady), .IMemData(IMemData2),
    .Instr_ID(Instr_ID2), .PCPlus4_ID(PCPlus4_ID2), .Valid_ID(Valid_ID2), .Imm16_ID(Imm16_ID2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // IF/ID snapshot plus request/address
  task automatic chk_if(input string tag, input logic [31:0] instr, input logic [31:0] pc4,
                        input logic vld, input logic req, input logic [31:0] addr);
    chk({tag, ".instr"}, Instr_ID, instr);
    chk({tag, ".pc4"},   PCPlus4_ID, pc4);
    chk({tag, ".valid"}, {31'd0, Valid_ID}, {31'd0, vld});
    chk({tag, ".req"},   {31'd0, IMemReq}, {31'd0, req});
    chk({tag, ".addr"},  IMemAddr, addr);
  endtask

  initial begin
    Reset_n = 1'b0; Stall = 1'b0; Flush = 1'b0; BranchTaken = 1'b0;
    BranchTarget = 32'h0; IMemReady = 1'b1;
    #12;
    chk_if("rst", 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("rst.addr2", IMemAddr2, 32'hFFFF_FFF8);
    chk("rst.req2", {31'd0, IMemReq2}, 32'd0);
    step();
    Reset_n = 1'b1;

    // zero-wait streaming
    step();
    chk_if("e1", 32'h0, 32'h0, 1'b0, 1'b1, 32'h0);
    chk("e1.addr2", IMemAddr2, 32'hFFFF_FFF8);
    step();
    chk_if("e2", 32'hA5A5_0000, 32'h4, 1'b1, 1'b1, 32'h4);
    chk("e2.addr2", IMemAddr2, 32'hFFFF_FFFC);
    step();
    chk_if("e3", 32'hA5A5_0004, 32'h8, 1'b1, 1'b1, 32'h8);
    chk("e3.addr2", IMemAddr2, 32'h0000_0000);
    chk("e3.pc4_2", PCPlus4_ID2, 32'h0000_0000);
    chk("e3.instr2", Instr_ID2, 32'hA5A5_FFFC);

    // stall with ready at PC=8 -> skid buffer, HOLD for 3 stalled edges
    Stall = 1'b1;
    step();
    chk_if("st1", 32'hA5A5_0004, 32'h8, 1'b1, 1'b0, 32'hC);
    step();
    chk_if("st2", 32'hA5A5_0004, 32'h8, 1'b1, 1'b0, 32'hC);
    step();
    chk_if("st3", 32'hA5A5_0004, 32'h8, 1'b1, 1'b0, 32'hC);
    Stall = 1'b0;
    step();
    chk_if("rel", 32'hA5A5_0008, 32'hC, 1'b1, 1'b1, 32'hC);
    step();
    chk_if("nxt", 32'hA5A5_000C, 32'h10, 1'b1, 1'b1, 32'h10);

    // wait states at PC=10 with a branch in the first wait cycle
    IMemReady = 1'b0; BranchTaken = 1'b1; BranchTarget = 32'h100;
    step();
    chk_if("br.w1", 32'h0, 32'h0, 1'b0, 1'b1, 32'h10);
    BranchTaken = 1'b0;
    step();
    chk_if("br.w2", 32'h0, 32'h0, 1'b0, 1'b1, 32'h10);
    IMemReady = 1'b1;
    step();
    chk_if("br.rdy", 32'h0, 32'h0, 1'b0, 1'b1, 32'h100);
    step();
    chk_if("br.tgt", 32'hA5A5_0100, 32'h104, 1'b1, 1'b1, 32'h104);

    // flush alone: bubble, PC still advances
    Flush = 1'b1;
    step();
    chk_if("fl", 32'h0, 32'h0, 1'b0, 1'b1, 32'h108);
    chk("fl.imm", {16'd0, Imm16_ID}, 32'h0);
    Flush = 1'b0;
    step();
    chk_if("fl.nxt", 32'hA5A5_0108, 32'h10C, 1'b1, 1'b1, 32'h10C);
    chk("fl.imm2", {16'd0, Imm16_ID}, 32'h0000_0108);

    // branch while stalled in HOLD drops the buffer; low target bits ignored
    Stall = 1'b1;
    step();
    chk_if("hb.hold", 32'hA5A5_0108, 32'h10C, 1'b1, 1'b0, 32'h110);
    BranchTaken = 1'b1; BranchTarget = 32'h203;
    step();
    chk_if("hb.br", 32'h0, 32'h0, 1'b0, 1'b1, 32'h200);
    BranchTaken = 1'b0; Stall = 1'b0;
    step();
    chk_if("hb.nxt", 32'hA5A5_0200, 32'h204, 1'b1, 1'b1, 32'h204);

    // flush in HOLD keeps the buffered word for release
    Stall = 1'b1;
    step();
    chk_if("hf.hold", 32'hA5A5_0200, 32'h204, 1'b1, 1'b0, 32'h208);
    Stall = 1'b0; Flush = 1'b1;
    step();
    chk_if("hf.fl", 32'h0, 32'h0, 1'b0, 1'b0, 32'h208);
    Flush = 1'b0;
    step();
    chk_if("hf.rel", 32'hA5A5_0204, 32'h208, 1'b1, 1'b1, 32'h208);

    // enter DRAIN, then async reset mid-cycle
    IMemReady = 1'b0; BranchTaken = 1'b1; BranchTarget = 32'h300;
    step();
    chk_if("dr", 32'h0, 32'h0, 1'b0, 1'b1, 32'h208);
    BranchTaken = 1'b0;
    #2;
    Reset_n = 1'b0;
    #1;
    chk_if("arst", 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("arst.addr2", IMemAddr2, 32'hFFFF_FFF8);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
